// File: rtl/any1_vagen_if.sv
// Request, index and effective-address streams of the ANY-1 address sequencer.
// The slave modport is the sequencer side; the master modport is the issuing side.
interface any1_vagen_if #(
    parameter int AWID = 32,
    parameter int VLEN = 64
);
    localparam int EW = $clog2(VLEN);

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      mode;
    logic [AWID-1:0] base;
    logic [AWID-1:0] imm;
    logic [AWID-1:0] stride;
    logic [2:0]      sc;
    logic [EW:0]     count;
    logic [VLEN-1:0] mask;
    logic            idx_valid;
    logic            idx_ready;
    logic [AWID-1:0] idx;
    logic            ea_valid;
    logic            ea_ready;
    logic [AWID-1:0] ea;
    logic [EW-1:0]   ea_elem;
    logic            ea_last;
    logic            done;
    logic            abort;

    modport master (
        output req_valid, mode, base, imm, stride, sc, count, mask,
               idx_valid, idx, ea_ready, abort,
        input  req_ready, idx_ready, ea_valid, ea, ea_elem, ea_last, done
    );

    modport slave (
        input  req_valid, mode, base, imm, stride, sc, count, mask,
               idx_valid, idx, ea_ready, abort,
        output req_ready, idx_ready, ea_valid, ea, ea_elem, ea_last, done
    );
endinterface

// File: rtl/any1_vagen.sv
// ANY-1 multi-element address sequencer: one op in, one effective address per element out.
// Optional per-element masking is enabled by defining ANY1_VAGEN_MASK_EN.
module any1_vagen #(
    parameter int AWID = 32,
    parameter int VLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    any1_vagen_if.slave   bus
);
    localparam int EW = $clog2(VLEN);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_RUN    = 1'b1;
    localparam logic [1:0]  M_SCALAR = 2'd0;
    localparam logic [1:0]  M_SCIDX  = 2'd1;
    localparam logic [1:0]  M_VIDX   = 2'd3;
    localparam logic [EW:0] ELEM_ONE = (EW+1)'(1);
    localparam logic [EW:0] VLEN_C   = (EW+1)'(VLEN);

    logic [0:0]      state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      sc_q, sc_d;
    logic [EW:0]     cnt_q, cnt_d;
    logic [EW:0]     elem_q, elem_d;
    logic [AWID-1:0] acc_q, acc_d;
    logic [AWID-1:0] stride_q, stride_d;

    logic            ea_valid_q, ea_valid_d;
    logic [AWID-1:0] ea_q, ea_d;
    logic [EW-1:0]   ea_elem_q, ea_elem_d;
    logic            ea_last_q, ea_last_d;
    logic            done_q, done_d;

    logic [EW:0]     cnt_in_s;
    logic [AWID-1:0] base_sum_s;
    logic            slot_free_s;
    logic            more_s;
    logic            idx_ready_s;
    logic            produce_s;
    logic            first_on_s;
    logic            run_on_s;

`ifdef ANY1_VAGEN_MASK_EN
    logic [VLEN-1:0] mask_q;

    // Element mask captured with the op; a cleared bit turns that element into a silent slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '0;
        end else if (state_q == S_IDLE && bus.req_valid) begin
            mask_q <= bus.mask;
        end else begin
            mask_q <= mask_q;
        end
    end

    assign first_on_s = bus.mask[0];
    assign run_on_s   = mask_q[elem_q[EW-1:0]];
`else
    logic mask_unused_s;

    assign mask_unused_s = ^bus.mask;
    assign first_on_s    = 1'b1;
    assign run_on_s      = 1'b1;
`endif

    // Effective element count of an incoming op: scalar forms are one element, others clamp to VLEN.
    always_comb begin
        if (bus.mode == M_SCALAR || bus.mode == M_SCIDX) begin
            cnt_in_s = ELEM_ONE;
        end else if (bus.count > VLEN_C) begin
            cnt_in_s = VLEN_C;
        end else begin
            cnt_in_s = bus.count;
        end
    end

    assign base_sum_s  = bus.base + bus.imm;
    assign slot_free_s = !ea_valid_q || bus.ea_ready;
    assign more_s      = elem_q < cnt_q;
    assign idx_ready_s = (state_q == S_RUN) && (mode_q == M_VIDX) && more_s
                         && slot_free_s && !bus.abort;
    assign produce_s   = (state_q == S_RUN) && more_s && slot_free_s && !bus.abort
                         && (mode_q != M_VIDX || bus.idx_valid);

    // Sequencer next state: op capture, per-element address generation and completion.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sc_d       = sc_q;
        cnt_d      = cnt_q;
        elem_d     = elem_q;
        acc_d      = acc_q;
        stride_d   = stride_q;
        ea_valid_d = ea_valid_q;
        ea_d       = ea_q;
        ea_elem_d  = ea_elem_q;
        ea_last_d  = ea_last_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    mode_d   = bus.mode;
                    sc_d     = bus.sc;
                    cnt_d    = cnt_in_s;
                    stride_d = bus.stride;
                    if (cnt_in_s == '0) begin
                        done_d = 1'b1;
                    end else if (bus.mode != M_VIDX) begin
                        // Element 0 is formed during accept so the first beat shows next cycle.
                        state_d    = S_RUN;
                        ea_valid_d = first_on_s;
                        ea_d       = (bus.mode == M_SCIDX) ? base_sum_s + (bus.stride << bus.sc)
                                                           : base_sum_s;
                        ea_elem_d  = '0;
                        ea_last_d  = (cnt_in_s == ELEM_ONE);
                        elem_d     = ELEM_ONE;
                        acc_d      = base_sum_s + bus.stride;
                    end else begin
                        state_d    = S_RUN;
                        ea_valid_d = 1'b0;
                        elem_d     = '0;
                        acc_d      = base_sum_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d    = S_IDLE;
                    ea_valid_d = 1'b0;
                end else begin
                    if (produce_s) begin
                        ea_valid_d = run_on_s;
                        ea_d       = (mode_q == M_VIDX) ? acc_q + (bus.idx << sc_q) : acc_q;
                        acc_d      = (mode_q == M_VIDX) ? acc_q : acc_q + stride_q;
                        ea_elem_d  = elem_q[EW-1:0];
                        ea_last_d  = (elem_q + ELEM_ONE == cnt_q);
                        elem_d     = elem_q + ELEM_ONE;
                    end else if (slot_free_s) begin
                        ea_valid_d = 1'b0;
                    end else begin
                        ea_valid_d = ea_valid_q;
                    end
                    // Every element issued and the output register drained: op complete.
                    if (!more_s && slot_free_s) begin
                        state_d    = S_IDLE;
                        ea_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                ea_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            sc_q       <= 3'd0;
            cnt_q      <= '0;
            elem_q     <= '0;
            acc_q      <= '0;
            stride_q   <= '0;
            ea_valid_q <= 1'b0;
            ea_q       <= '0;
            ea_elem_q  <= '0;
            ea_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sc_q       <= sc_d;
            cnt_q      <= cnt_d;
            elem_q     <= elem_d;
            acc_q      <= acc_d;
            stride_q   <= stride_d;
            ea_valid_q <= ea_valid_d;
            ea_q       <= ea_d;
            ea_elem_q  <= ea_elem_d;
            ea_last_q  <= ea_last_d;
            done_q     <= done_d;
        end
    end

    // req_ready follows rst directly so it is low throughout reset and high on the first cycle after.
    assign bus.req_ready = (state_q == S_IDLE) && rst;
    assign bus.idx_ready = idx_ready_s;
    assign bus.ea_valid  = ea_valid_q;
    assign bus.ea        = ea_q;
    assign bus.ea_elem   = ea_elem_q;
    assign bus.ea_last   = ea_last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_any1_vagen.sv
// Directed self-checking bench for any1_vagen with hand-computed address sequences.
module tb_any1_vagen;
    localparam int AWID = 32;
    localparam int VLEN = 64;

`ifdef ANY1_VAGEN_MASK_EN
    localparam logic [VLEN-1:0] MASK_DEF = {VLEN{1'b1}};
`else
    localparam logic [VLEN-1:0] MASK_DEF = {VLEN{1'b0}};
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    any1_vagen_if #(.AWID(AWID), .VLEN(VLEN)) bus();
    any1_vagen #(.AWID(AWID), .VLEN(VLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors_n = 0;
    int checks_n = 0;

    logic [31:0] got_ea[$];
    logic [31:0] got_elem[$];
    logic [31:0] got_last[$];
    logic [31:0] exp_ea[$];
    logic [31:0] exp_elem[$];
    logic [31:0] exp_last[$];
    logic [31:0] idx_list[$];
    int          idx_ptr;
    int          ncyc;
    bit          done_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [31:0] b, input logic [31:0] i,
                            input logic [31:0] s, input logic [2:0] scv, input int cnt,
                            input logic [VLEN-1:0] mk);
        bus.mode      = m;
        bus.base      = b;
        bus.imm       = i;
        bus.stride    = s;
        bus.sc        = scv;
        bus.count     = 7'(cnt);
        bus.mask      = mk;
        bus.ea_ready  = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] e, input logic [31:0] el, input logic [31:0] la);
        exp_ea.push_back(e);
        exp_elem.push_back(el);
        exp_last.push_back(la);
    endtask

    // Runs from the cycle after accept until done, collecting handshaken beats.
    task automatic run_op(input int budget, input bit toggle, input bit gaps,
                          output int n, output bit ok);
        bit          held = 1'b0;
        logic [31:0] h_ea = 32'd0;
        logic [31:0] h_elem = 32'd0;
        logic [31:0] h_last = 32'd0;
        n  = 0;
        ok = 1'b0;
        idx_ptr = 0;
        while (n < budget) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            bus.ea_ready = toggle ? ((n % 3) != 1) : 1'b1;
            if (idx_ptr < idx_list.size() && (!gaps || (n % 2) == 0)) begin
                bus.idx_valid = 1'b1;
                bus.idx       = idx_list[idx_ptr];
            end else begin
                bus.idx_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("hold_valid", 32'(bus.ea_valid), 32'd1);
                chk("hold_ea", bus.ea, h_ea);
                chk("hold_elem", 32'(bus.ea_elem), h_elem);
                chk("hold_last", 32'(bus.ea_last), h_last);
            end
            if (bus.ea_valid && bus.ea_ready) begin
                got_ea.push_back(bus.ea);
                got_elem.push_back(32'(bus.ea_elem));
                got_last.push_back(32'(bus.ea_last));
            end
            held   = bus.ea_valid && !bus.ea_ready;
            h_ea   = bus.ea;
            h_elem = 32'(bus.ea_elem);
            h_last = 32'(bus.ea_last);
            if (bus.idx_valid && bus.idx_ready) idx_ptr++;
            tick();
            n++;
        end
        bus.idx_valid = 1'b0;
        bus.ea_ready  = 1'b1;
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic cmp_beats(input string tag);
        int n;
        chk({tag, "_nbeats"}, 32'(got_ea.size()), 32'(exp_ea.size()));
        n = (got_ea.size() < exp_ea.size()) ? got_ea.size() : exp_ea.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_ea"}, got_ea[k], exp_ea[k]);
            chk({tag, "_elem"}, got_elem[k], exp_elem[k]);
            chk({tag, "_last"}, got_last[k], exp_last[k]);
        end
        got_ea.delete(); got_elem.delete(); got_last.delete();
        exp_ea.delete(); exp_elem.delete(); exp_last.delete();
        idx_list.delete();
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.mode = 2'd0; bus.base = 32'd0; bus.imm = 32'd0;
        bus.stride = 32'd0; bus.sc = 3'd0; bus.count = 7'd0; bus.mask = MASK_DEF;
        bus.idx_valid = 1'b0; bus.idx = 32'd0; bus.ea_ready = 1'b1; bus.abort = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_ea_valid", 32'(bus.ea_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_idx_ready", 32'(bus.idx_ready), 32'd0);
        chk("rst_ea", bus.ea, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Mode 0 scalar
        start_op(2'd0, 32'h1000, 32'h10, 32'd0, 3'd0, 0, MASK_DEF);
        chk("m0_req_ready_run", 32'(bus.req_ready), 32'd0);
        expect_beat(32'h1010, 32'd0, 32'd1);
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        chk("m0_done_lat", 32'(ncyc), 32'd1);
        chk("m0_req_ready_done", 32'(bus.req_ready), 32'd1);
        cmp_beats("m0");
        tick();
        chk("m0_done_pulse", 32'(bus.done), 32'd0);

        // Mode 1 scaled index; count is ignored
        start_op(2'd1, 32'h100, 32'h4, 32'd3, 3'd3, 5, MASK_DEF);
        expect_beat(32'h11C, 32'd0, 32'd1);
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        cmp_beats("m1");

        // Mode 2 strided, full rate
        start_op(2'd2, 32'h2000, 32'd0, 32'd8, 3'd0, 4, MASK_DEF);
        for (int k = 0; k < 4; k++) expect_beat(32'h2000 + 32'(k) * 32'd8, 32'(k), 32'(k == 3));
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        chk("m2_cycles", 32'(ncyc), 32'd4);
        cmp_beats("m2");

        // Mode 3 vector-indexed with index gaps and downstream stalls
        idx_list.push_back(32'd1); idx_list.push_back(32'd5); idx_list.push_back(32'd0);
        start_op(2'd3, 32'h3000, 32'd0, 32'hDEAD, 3'd2, 3, MASK_DEF);
        expect_beat(32'h3004, 32'd0, 32'd0);
        expect_beat(32'h3014, 32'd1, 32'd0);
        expect_beat(32'h3000, 32'd2, 32'd1);
        run_op(100, 1'b1, 1'b1, ncyc, done_ok);
        chk("m3_idx_used", 32'(idx_ptr), 32'd3);
        cmp_beats("m3");

        // Address wrap
        start_op(2'd2, 32'hFFFF_FFF8, 32'd0, 32'd8, 3'd0, 2, MASK_DEF);
        expect_beat(32'hFFFF_FFF8, 32'd0, 32'd0);
        expect_beat(32'h0000_0000, 32'd1, 32'd1);
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        cmp_beats("wrap");

        // count==0, strided and vector-indexed
        start_op(2'd2, 32'h4000, 32'd0, 32'd4, 3'd0, 0, MASK_DEF);
        chk("c0_done", 32'(bus.done), 32'd1);
        chk("c0_ea_valid", 32'(bus.ea_valid), 32'd0);
        chk("c0_req_ready", 32'(bus.req_ready), 32'd1);
        bus.idx_valid = 1'b1;
        start_op(2'd3, 32'h4000, 32'd0, 32'd4, 3'd0, 0, MASK_DEF);
        chk("c0v_done", 32'(bus.done), 32'd1);
        chk("c0v_idx_ready", 32'(bus.idx_ready), 32'd0);
        bus.idx_valid = 1'b0;
        tick();

        // count clamps to VLEN
        start_op(2'd2, 32'd0, 32'd0, 32'd1, 3'd0, 100, MASK_DEF);
        for (int k = 0; k < VLEN; k++) expect_beat(32'(k), 32'(k), 32'(k == VLEN - 1));
        run_op(200, 1'b0, 1'b0, ncyc, done_ok);
        cmp_beats("clamp");

        // abort after beat 2
        start_op(2'd2, 32'h500, 32'd0, 32'd4, 3'd0, 10, MASK_DEF);
        tick();
        tick();
        chk("ab_beat2_ea", bus.ea, 32'h508);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_ea_valid", 32'(bus.ea_valid), 32'd0);
        chk("ab_done", 32'(bus.done), 32'd0);
        chk("ab_req_ready", 32'(bus.req_ready), 32'd1);
        chk("ab_idx_ready", 32'(bus.idx_ready), 32'd0);
        tick();
        chk("ab_done_late", 32'(bus.done), 32'd0);

        // abort in IDLE does not block an accept
        bus.abort = 1'b1;
        start_op(2'd0, 32'h77, 32'h1, 32'd0, 3'd0, 0, MASK_DEF);
        bus.abort = 1'b0;
        expect_beat(32'h78, 32'd0, 32'd1);
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        cmp_beats("ab_idle");

        // reset mid-op
        start_op(2'd2, 32'h600, 32'd0, 32'd4, 3'd0, 8, MASK_DEF);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_ea_valid", 32'(bus.ea_valid), 32'd0);
        chk("mr_done", 32'(bus.done), 32'd0);
        chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_done_after", 32'(bus.done), 32'd0);
        chk("mr_req_ready_after", 32'(bus.req_ready), 32'd1);

`ifdef ANY1_VAGEN_MASK_EN
        start_op(2'd2, 32'd0, 32'd0, 32'd4, 3'd0, 4, 64'b1010);
        expect_beat(32'd4, 32'd1, 32'd0);
        expect_beat(32'd12, 32'd3, 32'd1);
        run_op(50, 1'b0, 1'b0, ncyc, done_ok);
        chk("mask_cycles", 32'(ncyc), 32'd4);
        cmp_beats("mask");
`endif

        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end
endmodule
